// File: rtl/reg_file_if.sv
// reg_file_if: register-file access bundle.
//   rs1, rs2 : read addresses, ports 1 and 2
//   rd       : write address
//   we       : write enable
//   wd       : write data
//   rd1, rd2 : read data, ports 1 and 2 (combinational)
// master drives addresses/write side and receives read data;
// slave is the register file itself.
interface reg_file_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [ADDR_W-1:0] rd;
  logic              we;
  logic [WIDTH-1:0]  wd;
  logic [WIDTH-1:0]  rd1;
  logic [WIDTH-1:0]  rd2;

  modport master (
    output rs1, rs2, rd, we, wd,
    input  rd1, rd2
  );

  modport slave (
    input  rs1, rs2, rd, we, wd,
    output rd1, rd2
  );
endinterface

// File: rtl/reg_file.sv
// reg_file: DEPTH x WIDTH architectural register file, two combinational
// read ports, one write port, hard-wired zero register.
//   clk  : rising-edge clock for writes
//   rst  : asynchronous active-high reset; clears every register and
//          forces both read ports to 0 while held
//   bus  : reg_file_if slave (rs1/rs2/rd/we/wd in, rd1/rd2 out)
// A write to the register being read is forwarded to the read port in
// the same cycle (write-through bypass); address 0 never bypasses.
module reg_file #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  reg_file_if.slave   bus
);

  // Register 0 has no storage; reads of address 0 are decoded to zero.
  logic [WIDTH-1:0] regs [1:DEPTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.we && bus.rd != '0) begin
      regs[bus.rd] <= bus.wd;
    end
  end

  // rd==rsN together with rsN!=0 already implies rd!=0, so the nonzero
  // address test covers the x0 bypass exclusion as well.
  always_comb begin
    bus.rd1 = '0;
    bus.rd2 = '0;
    if (!rst) begin
      if (bus.rs1 != '0) begin
        bus.rd1 = (bus.we && bus.rd == bus.rs1) ? bus.wd : regs[bus.rs1];
      end
      if (bus.rs2 != '0) begin
        bus.rd2 = (bus.we && bus.rd == bus.rs2) ? bus.wd : regs[bus.rs2];
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

  logic clk   = 1'b0;
  logic clkEn = 1'b0;
  logic rst   = 1'b0;

  reg_file_if #(.WIDTH(32), .ADDR_W(5)) bus ();

  reg_file #(.WIDTH(32), .DEPTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 if (clkEn) clk = ~clk;

  int nTests = 0;
  int nFail  = 0;

  // Behavioural model: plain array of architectural values.
  logic [31:0] mdl [32];

  function automatic logic [31:0] refRead(input logic [4:0] a);
    if (rst || a == 5'd0) return 32'h0;
    if (bus.we && bus.rd == a) return bus.wd;
    return mdl[a];
  endfunction

  task automatic setIn(input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] d, input logic w,
                       input logic [31:0] data);
    bus.rs1 = a1;
    bus.rs2 = a2;
    bus.rd  = d;
    bus.we  = w;
    bus.wd  = data;
  endtask

  // One rising edge; the model commits what the DUT should commit.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    end else if (bus.we && bus.rd != 5'd0) begin
      mdl[bus.rd] = bus.wd;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    setIn(5'd5, 5'd31, 5'd0, 1'b0, 32'h0);
    #1 rst = 1'b1;
    #2;
    nTests++;
    if (bus.rd1 !== 32'h0) begin
      nFail++; $display("FAIL reset_rd1: got %h expected %h", bus.rd1, 32'h0);
    end
    nTests++;
    if (bus.rd2 !== 32'h0) begin
      nFail++; $display("FAIL reset_rd2: got %h expected %h", bus.rd2, 32'h0);
    end
    clkEn = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    nTests++;
    if (bus.rd1 !== 32'h0 || bus.rd2 !== 32'h0) begin
      nFail++; $display("FAIL reset_idle: got %h/%h expected 0/0", bus.rd1, bus.rd2);
    end
  endtask

  task automatic test_write_read();
    setIn(5'd5, 5'd31, 5'd5, 1'b1, 32'h01001001);
    tick();
    setIn(5'd5, 5'd31, 5'd31, 1'b1, 32'hDEADBEEF);
    tick();
    setIn(5'd5, 5'd31, 5'd0, 1'b0, 32'h0);
    #1;
    nTests++;
    if (bus.rd1 !== 32'h01001001) begin
      nFail++; $display("FAIL wr_x5: got %h expected %h", bus.rd1, 32'h01001001);
    end
    nTests++;
    if (bus.rd2 !== 32'hDEADBEEF) begin
      nFail++; $display("FAIL wr_x31: got %h expected %h", bus.rd2, 32'hDEADBEEF);
    end
    bus.rs1 = 5'd6;
    #1;
    nTests++;
    if (bus.rd1 !== 32'h0) begin
      nFail++; $display("FAIL rd_x6: got %h expected %h", bus.rd1, 32'h0);
    end
  endtask

  task automatic test_x0();
    setIn(5'd0, 5'd0, 5'd0, 1'b1, 32'hFFFFFFFF);
    #1;
    nTests++;
    if (bus.rd1 !== 32'h0 || bus.rd2 !== 32'h0) begin
      nFail++; $display("FAIL x0_pre: got %h/%h expected 0/0", bus.rd1, bus.rd2);
    end
    tick();
    nTests++;
    if (bus.rd1 !== 32'h0) begin
      nFail++; $display("FAIL x0_post: got %h expected %h", bus.rd1, 32'h0);
    end
    bus.we = 1'b0;
    for (int i = 1; i < 32; i++) begin
      bus.rs1 = 5'(i);
      bus.rs2 = 5'(i);
      #1;
      nTests++;
      if (bus.rd1 !== mdl[i] || bus.rd2 !== mdl[i]) begin
        nFail++;
        $display("FAIL x0_hold x%0d: got %h/%h expected %h", i, bus.rd1, bus.rd2, mdl[i]);
      end
    end
  endtask

  task automatic test_bypass();
    setIn(5'd7, 5'd7, 5'd7, 1'b1, 32'h00000011);
    tick();
    setIn(5'd7, 5'd7, 5'd7, 1'b1, 32'h00000022);
    #1;
    nTests++;
    if (bus.rd1 !== 32'h22 || bus.rd2 !== 32'h22) begin
      nFail++; $display("FAIL bypass_pre: got %h/%h expected 00000022", bus.rd1, bus.rd2);
    end
    tick();
    bus.we = 1'b0;
    #1;
    nTests++;
    if (bus.rd1 !== 32'h22 || bus.rd2 !== 32'h22) begin
      nFail++; $display("FAIL bypass_post: got %h/%h expected 00000022", bus.rd1, bus.rd2);
    end
  endtask

  task automatic test_async_reset();
    setIn(5'd5, 5'd31, 5'd5, 1'b1, 32'h01001001);
    tick();
    bus.we = 1'b0;
    #1;
    nTests++;
    if (bus.rd1 !== 32'h01001001) begin
      nFail++; $display("FAIL arst_pre: got %h expected %h", bus.rd1, 32'h01001001);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    nTests++;
    if (bus.rd1 !== 32'h0) begin
      nFail++; $display("FAIL arst_immediate: got %h expected %h", bus.rd1, 32'h0);
    end
    setIn(5'd5, 5'd31, 5'd5, 1'b1, 32'hCAFEF00D);
    tick();
    @(negedge clk);
    rst = 1'b0;
    bus.we = 1'b0;
    #1;
    nTests++;
    if (bus.rd1 !== 32'h0) begin
      nFail++; $display("FAIL arst_write_discard: got %h expected %h", bus.rd1, 32'h0);
    end
    nTests++;
    if (bus.rd2 !== 32'h0) begin
      nFail++; $display("FAIL arst_clear_x31: got %h expected %h", bus.rd2, 32'h0);
    end
    setIn(5'd5, 5'd31, 5'd5, 1'b1, 32'hA5A5A5A5);
    tick();
    bus.we = 1'b0;
    #1;
    nTests++;
    if (bus.rd1 !== 32'hA5A5A5A5) begin
      nFail++; $display("FAIL arst_first_write: got %h expected %h", bus.rd1, 32'hA5A5A5A5);
    end
  endtask

  task automatic test_sweep();
    for (int i = 1; i < 32; i++) begin
      setIn(5'd0, 5'd0, 5'(i), 1'b1, i * 32'h01010101);
      tick();
    end
    bus.we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      logic [31:0] e1, e2;
      e1 = i * 32'h01010101;
      e2 = (31 - i) * 32'h01010101;
      bus.rs1 = 5'(i);
      bus.rs2 = 5'(31 - i);
      #1;
      nTests++;
      if (bus.rd1 !== e1 || bus.rd2 !== e2) begin
        nFail++;
        $display("FAIL sweep pair %0d: got %h/%h expected %h/%h", i, bus.rd1, bus.rd2, e1, e2);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      setIn(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 3) == 0) bus.rs1 = bus.rd;
      if ($urandom_range(0, 3) == 0) bus.rs2 = bus.rs1;
      if ($urandom_range(0, 7) == 0) bus.rd = 5'd0;
      #1;
      nTests++;
      if (bus.rd1 !== refRead(bus.rs1) || bus.rd2 !== refRead(bus.rs2)) begin
        nFail++;
        $display("FAIL random %0d rs1=%0d rs2=%0d rd=%0d we=%0b: got %h/%h expected %h/%h",
                 n, bus.rs1, bus.rs2, bus.rd, bus.we, bus.rd1, bus.rd2,
                 refRead(bus.rs1), refRead(bus.rs2));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_x0();
    test_bypass();
    test_async_reset();
    test_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter DEPTH, default 32, number of architectural registers; address width is log2(DEPTH) = 5.
REQ-003 Clock is clk and reset is rst; reset is asynchronous and active-high.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 rs1  input  5  read address, port 1.
REQ-007 rs2  input  5  read address, port 2.
REQ-008 rd  input  5  write address.
REQ-009 we  input  1  write enable, sampled on the rising edge of clk.
REQ-010 wd  input  WIDTH  write data.
REQ-011 rd1  output  WIDTH  read data, port 1; feeds the ALU operand-A path.
REQ-012 rd2  output  WIDTH  read data, port 2; feeds i1 of the ALU source-B 2:1 mux and the store-data path.

Function
REQ-013 Storage SHALL be DEPTH registers of WIDTH bits; register 0 SHALL read 0 at all times.
REQ-014 A write SHALL occur on the rising edge of clk when we=1 and rd!=0: reg[rd] <= wd.
REQ-015 When we=1 and rd=0, no register SHALL change, and the write SHALL be silently discarded.
REQ-016 When we=0, no register SHALL change.
REQ-017 Reads SHALL be combinational with zero-cycle latency: rd1 = reg[rs1] and rd2 = reg[rs2].
REQ-018 Write-through bypass: while we=1, rd!=0 and rs1==rd, rd1 SHALL equal wd combinationally in the same cycle; likewise for rd2 when rs2==rd.
REQ-019 Bypass SHALL never apply to address 0: rs1=0 or rs2=0 SHALL yield 0 regardless of we, rd and wd.
REQ-020 Both ports SHALL be independent: rs1==rs2 SHALL return identical data on rd1 and rd2, including the bypass case.
REQ-021 Each write SHALL update exactly one register; all other registers SHALL hold their values.
REQ-022 Outputs SHALL have no X after reset for any address input value.

Reset
REQ-023 While rst=1, all registers SHALL be cleared to 0 immediately, without waiting for a clk edge.
REQ-024 While rst=1, rd1 and rd2 SHALL read 0 for every address, and the bypass SHALL be inhibited.
REQ-025 A write whose clk edge coincides with rst=1 SHALL be discarded.
REQ-026 Reset asserted mid-operation SHALL discard all prior contents; after rst falls, the first write SHALL take effect on the first rising clk edge with we=1.

Verification
REQ-027 Reset: drive rst=1 with no clk edge; set rs1=5, rs2=31 -> rd1=0 and rd2=0. Release rst, clock 2 cycles with we=0 -> both outputs remain 0.
REQ-028 Write/read: write 32'h01001001 to x5 and 32'hDEADBEEF to x31 on successive edges, then set we=0, rs1=5, rs2=31 -> rd1=32'h01001001 and rd2=32'hDEADBEEF. Set rs1=6 -> rd1=0.
REQ-029 x0 protection: we=1, rd=0, wd=32'hFFFFFFFF, rs1=0; clock one edge -> rd1=0 both before and after the edge. Check that x1..x31 are unchanged.
REQ-030 Bypass: x7 holds 32'h00000011; drive we=1, rd=7, wd=32'h00000022, rs1=7, rs2=7 before the edge -> rd1=rd2=32'h00000022. After the edge with we=0 -> both still read 32'h00000022.
REQ-031 Async reset mid-operation: with x5=32'h01001001, pulse rst=1 between clk edges -> rd1 (rs1=5) drops to 0 before the next edge. A write at the edge while rst=1 has no effect.
REQ-032 Sweep: write reg[i]=i*32'h01010101 for i=1..31, then read all pairs (i, 31-i) -> each port returns the written value, and x0 returns 0.
